// File: rtl/ex_mul_pkg.sv
// Shared constants and helpers for the pipelined RV32 multiplier.
package ex_mul_pkg;

  localparam int RV32_DATA_WIDTH = 32;
  localparam int RRF_ENT_SEL     = 6;

  localparam int EXT_W  = RV32_DATA_WIDTH + 1;   // 33-bit extended operand
  localparam int HALF_W = 16;                    // low-half width of an operand split
  localparam int PP_W   = 2 * (EXT_W - HALF_W);  // 34 bits holds any half x half product
  localparam int PROD_W = 2 * EXT_W;             // 66-bit full signed product

  function automatic logic [PROD_W-1:0] sext_pp(input logic [PP_W-1:0] pp);
    return {{(PROD_W-PP_W){pp[PP_W-1]}}, pp};
  endfunction

endpackage

// File: rtl/ex_mul_pp.sv
// Partial-product generator: 33x33 signed operands split into 17-bit signed high and
// 16-bit unsigned low halves, four 34-bit signed products out; purely combinational.
module mul_pp
  import ex_mul_pkg::*;
(
  input  logic [EXT_W-1:0] a_i,
  input  logic [EXT_W-1:0] b_i,
  output logic [PP_W-1:0]  pp_ll_o,
  output logic [PP_W-1:0]  pp_lh_o,
  output logic [PP_W-1:0]  pp_hl_o,
  output logic [PP_W-1:0]  pp_hh_o
);

  logic signed [PP_W-1:0] a_lo, a_hi, b_lo, b_hi;

  // Halves widened to the product width so every multiply is full-width signed.
  assign a_lo = {{(PP_W-HALF_W){1'b0}}, a_i[HALF_W-1:0]};
  assign b_lo = {{(PP_W-HALF_W){1'b0}}, b_i[HALF_W-1:0]};
  assign a_hi = {{(PP_W-(EXT_W-HALF_W)){a_i[EXT_W-1]}}, a_i[EXT_W-1:HALF_W]};
  assign b_hi = {{(PP_W-(EXT_W-HALF_W)){b_i[EXT_W-1]}}, b_i[EXT_W-1:HALF_W]};

  assign pp_ll_o = a_lo * b_lo;
  assign pp_lh_o = a_lo * b_hi;
  assign pp_hl_o = a_hi * b_lo;
  assign pp_hh_o = a_hi * b_hi;

endmodule

// File: rtl/ex_mul.sv
// Fully pipelined RV32 MUL/MULH/MULHSU/MULHU unit: result 3 cycles after issue.
// Accepts one op per cycle with no backpressure; i_kill drops everything in flight.
module ex_mul
  import ex_mul_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_is_vld,
  input  logic                       i_mul_signed1,
  input  logic                       i_mul_signed2,
  input  logic                       i_mul_sel_high,
  input  logic [RV32_DATA_WIDTH-1:0] i_rs1_srcopr,
  input  logic [RV32_DATA_WIDTH-1:0] i_rs2_srcopr,
  input  logic [RRF_ENT_SEL-1:0]     i_rrftag,
  input  logic                       i_kill,
  output logic                       o_exfin_mul,
  output logic [RRF_ENT_SEL-1:0]     o_ex_mul_rrftag,
  output logic [RV32_DATA_WIDTH-1:0] o_exfin_mul_res,
  output logic                       o_busy
);

  logic                   s1_vld_q, s2_vld_q, s3_vld_q;
  logic                   s1_vld_d, s2_vld_d, s3_vld_d;
  logic [EXT_W-1:0]       s1_a_q, s1_b_q, a_ext_d, b_ext_d;
  logic [RRF_ENT_SEL-1:0] s1_tag_q, s2_tag_q, res_tag_q;
  logic                   s1_hi_q, s2_hi_q;
  logic [PP_W-1:0]        pp_ll_d, pp_lh_d, pp_hl_d, pp_hh_d;
  logic [PP_W-1:0]        pp_ll_q, pp_lh_q, pp_hl_q, pp_hh_q;
  logic [PROD_W-1:0]      prod_d;
  logic [RV32_DATA_WIDTH-1:0] res_d, res_q;

  assign a_ext_d = {i_mul_signed1 & i_rs1_srcopr[RV32_DATA_WIDTH-1], i_rs1_srcopr};
  assign b_ext_d = {i_mul_signed2 & i_rs2_srcopr[RV32_DATA_WIDTH-1], i_rs2_srcopr};

  // A kill wins over every stage, including an issue arriving in the same cycle.
  assign s1_vld_d = i_is_vld & ~i_kill;
  assign s2_vld_d = s1_vld_q & ~i_kill;
  assign s3_vld_d = s2_vld_q & ~i_kill;

  mul_pp u_mul_pp (
    .a_i     (s1_a_q),
    .b_i     (s1_b_q),
    .pp_ll_o (pp_ll_d),
    .pp_lh_o (pp_lh_d),
    .pp_hl_o (pp_hl_d),
    .pp_hh_o (pp_hh_d)
  );

  assign prod_d = (sext_pp(pp_hh_q) << (2 * HALF_W))
                + (sext_pp(pp_lh_q) << HALF_W)
                + (sext_pp(pp_hl_q) << HALF_W)
                +  sext_pp(pp_ll_q);

  assign res_d = s2_hi_q ? prod_d[2*RV32_DATA_WIDTH-1:RV32_DATA_WIDTH]
                         : prod_d[RV32_DATA_WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q  <= 1'b0;
      s2_vld_q  <= 1'b0;
      s3_vld_q  <= 1'b0;
      s1_a_q    <= '0;
      s1_b_q    <= '0;
      s1_tag_q  <= '0;
      s1_hi_q   <= 1'b0;
      pp_ll_q   <= '0;
      pp_lh_q   <= '0;
      pp_hl_q   <= '0;
      pp_hh_q   <= '0;
      s2_tag_q  <= '0;
      s2_hi_q   <= 1'b0;
      res_q     <= '0;
      res_tag_q <= '0;
    end else begin
      s1_vld_q <= s1_vld_d;
      s2_vld_q <= s2_vld_d;
      s3_vld_q <= s3_vld_d;
      if (s1_vld_d) begin
        s1_a_q   <= a_ext_d;
        s1_b_q   <= b_ext_d;
        s1_tag_q <= i_rrftag;
        s1_hi_q  <= i_mul_sel_high;
      end
      if (s2_vld_d) begin
        pp_ll_q  <= pp_ll_d;
        pp_lh_q  <= pp_lh_d;
        pp_hl_q  <= pp_hl_d;
        pp_hh_q  <= pp_hh_d;
        s2_tag_q <= s1_tag_q;
        s2_hi_q  <= s1_hi_q;
      end
      if (s3_vld_d) begin
        res_q     <= res_d;
        res_tag_q <= s2_tag_q;
      end
    end
  end

  assign o_exfin_mul     = s3_vld_q;
  assign o_ex_mul_rrftag = res_tag_q;
  assign o_exfin_mul_res = res_q;
  assign o_busy          = s1_vld_q | s2_vld_q | s3_vld_q;

endmodule

// File: tb/tb_ex_mul.sv
// Directed-vector bench for ex_mul with a short random tail against a 64-bit product model.
module tb_ex_mul;
  import ex_mul_pkg::*;

  logic                       clk;
  logic                       rst_n;
  logic                       i_is_vld, i_mul_signed1, i_mul_signed2, i_mul_sel_high, i_kill;
  logic [RV32_DATA_WIDTH-1:0] i_rs1_srcopr, i_rs2_srcopr;
  logic [RRF_ENT_SEL-1:0]     i_rrftag;
  logic                       o_exfin_mul, o_busy;
  logic [RRF_ENT_SEL-1:0]     o_ex_mul_rrftag;
  logic [RV32_DATA_WIDTH-1:0] o_exfin_mul_res;

  int checks;
  int errors;

  typedef struct {
    int                         due;
    logic [RRF_ENT_SEL-1:0]     tag;
    logic [RV32_DATA_WIDTH-1:0] res;
  } exp_t;
  exp_t exp_q[$];

  ex_mul dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_is_vld        (i_is_vld),
    .i_mul_signed1   (i_mul_signed1),
    .i_mul_signed2   (i_mul_signed2),
    .i_mul_sel_high  (i_mul_sel_high),
    .i_rs1_srcopr    (i_rs1_srcopr),
    .i_rs2_srcopr    (i_rs2_srcopr),
    .i_rrftag        (i_rrftag),
    .i_kill          (i_kill),
    .o_exfin_mul     (o_exfin_mul),
    .o_ex_mul_rrftag (o_ex_mul_rrftag),
    .o_exfin_mul_res (o_exfin_mul_res),
    .o_busy          (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic vld, input logic s1, input logic s2, input logic hi,
                       input logic [31:0] a, input logic [31:0] b, input logic [5:0] tag);
    i_is_vld       = vld;
    i_mul_signed1  = s1;
    i_mul_signed2  = s2;
    i_mul_sel_high = hi;
    i_rs1_srcopr   = a;
    i_rs2_srcopr   = b;
    i_rrftag       = tag;
  endtask

  function automatic logic [31:0] ref_mul(input logic s1, input logic s2, input logic hi,
                                          input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb, p;
    ea = s1 ? {{32{a[31]}}, a} : {32'd0, a};
    eb = s2 ? {{32{b[31]}}, b} : {32'd0, b};
    p  = ea * eb;
    return hi ? p[63:32] : p[31:0];
  endfunction

  // One isolated op: issue, wait three edges, expect exactly one finish pulse.
  task automatic run1(input string name, input logic s1, input logic s2, input logic hi,
                      input logic [31:0] a, input logic [31:0] b, input logic [5:0] tag,
                      input logic [31:0] exp_res);
    drive(1'b1, s1, s2, hi, a, b, tag);
    step();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 6'd0);
    chk({name, "_busy"}, 64'(o_busy), 64'd1);
    chk({name, "_early"}, 64'(o_exfin_mul), 64'd0);
    step();
    step();
    chk({name, "_vld"}, 64'(o_exfin_mul), 64'd1);
    chk({name, "_tag"}, 64'(o_ex_mul_rrftag), 64'(tag));
    chk({name, "_res"}, 64'(o_exfin_mul_res), 64'(exp_res));
    step();
    chk({name, "_once"}, 64'(o_exfin_mul), 64'd0);
    chk({name, "_idle"}, 64'(o_busy), 64'd0);
  endtask

  initial begin
    logic [31:0] a, b;
    logic [2:0]  fl;
    logic [5:0]  tg;
    logic [31:0] corner [0:5];
    checks = 0;
    errors = 0;
    corner[0] = 32'h0000_0000; corner[1] = 32'hFFFF_FFFF; corner[2] = 32'h8000_0000;
    corner[3] = 32'h7FFF_FFFF; corner[4] = 32'h0000_FFFF; corner[5] = 32'hFFFF_0000;

    rst_n  = 1'b0;
    i_kill = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 6'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_exfin", 64'(o_exfin_mul), 64'd0);
    chk("rst_busy",  64'(o_busy), 64'd0);
    chk("rst_res",   64'(o_exfin_mul_res), 64'd0);
    chk("rst_tag",   64'(o_ex_mul_rrftag), 64'd0);
    rst_n = 1'b1;
    step();

    run1("mulhu_ff", 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd5, 32'hFFFF_FFFE);
    run1("mul_ff",   1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd5, 32'h0000_0001);
    run1("mulh_ff",  1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd7, 32'h0000_0000);
    run1("mulhsu_ff",1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd8, 32'hFFFF_FFFF);
    run1("mulh_min", 1'b1, 1'b1, 1'b1, 32'h8000_0000, 32'h8000_0000, 6'd9, 32'h4000_0000);
    // rs2-only signed: 0xFFFFFFFF * -1 = -(2^32-1) -> high word all ones.
    run1("rs2only",  1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd10, 32'hFFFF_FFFF);
    // -2 * 3 signed = -6, low word 0xFFFFFFFA.
    run1("mul_neg",  1'b1, 1'b1, 1'b0, 32'hFFFF_FFFE, 32'h0000_0003, 6'd11, 32'hFFFF_FFFA);

    // Four back-to-back issues, rs1 = 3k, rs2 = k.
    for (int c = 0; c < 8; c++) begin
      if (c < 4) drive(1'b1, 1'b0, 1'b0, 1'b0, 32'(3 * (c + 1)), 32'(c + 1), 6'(c + 1));
      else       drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 6'd0);
      if (c >= 3 && c <= 6) begin
        chk($sformatf("b2b_vld%0d", c), 64'(o_exfin_mul), 64'd1);
        chk($sformatf("b2b_tag%0d", c), 64'(o_ex_mul_rrftag), 64'(c - 2));
        chk($sformatf("b2b_res%0d", c), 64'(o_exfin_mul_res), 64'(3 * (c - 2) * (c - 2)));
      end else if (c > 6) begin
        chk("b2b_tail", 64'(o_exfin_mul), 64'd0);
      end
      step();
    end

    // Kill on the third issue flushes all three.
    for (int c = 0; c < 6; c++) begin
      if (c < 3) drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd2, 32'd2, 6'(c + 1));
      else       drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 6'd0);
      i_kill = (c == 2);
      if (c >= 3) chk($sformatf("kill_vld%0d", c), 64'(o_exfin_mul), 64'd0);
      if (c == 3) chk("kill_busy", 64'(o_busy), 64'd0);
      step();
    end
    i_kill = 1'b0;

    // Reset one cycle after an issue discards it.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd6, 32'd7, 6'd12);
    step();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 6'd0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_exfin", 64'(o_exfin_mul), 64'd0);
    chk("mid_rst_busy",  64'(o_busy), 64'd0);
    chk("mid_rst_res",   64'(o_exfin_mul_res), 64'd0);
    chk("mid_rst_tag",   64'(o_ex_mul_rrftag), 64'd0);
    step();
    rst_n = 1'b1;
    for (int c = 2; c <= 6; c++) begin
      chk($sformatf("post_rst%0d", c), 64'(o_exfin_mul), 64'd0);
      step();
    end

    // Random tail over all flag combinations, scored against a queue of expected finishes.
    for (int c = 0; c < 400; c++) begin
      if (exp_q.size() > 0 && exp_q[0].due == c) begin
        chk("rnd_vld", 64'(o_exfin_mul), 64'd1);
        chk("rnd_tag", 64'(o_ex_mul_rrftag), 64'(exp_q[0].tag));
        chk("rnd_res", 64'(o_exfin_mul_res), 64'(exp_q[0].res));
        void'(exp_q.pop_front());
      end else begin
        chk("rnd_idle", 64'(o_exfin_mul), 64'd0);
      end
      if (c < 390 && $urandom_range(0, 3) != 0) begin
        a  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
        b  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
        fl = 3'($urandom_range(0, 7));
        tg = 6'($urandom_range(0, 63));
        drive(1'b1, fl[0], fl[1], fl[2], a, b, tg);
        exp_q.push_back('{due: c + 3, tag: tg, res: ref_mul(fl[0], fl[1], fl[2], a, b)});
      end else begin
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 6'd0);
      end
      step();
    end
    chk("rnd_drained", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
